// File: rtl/aca_pkg.sv
// Shared defaults and FSM encoding for the almost-correct adder recovery stage.
package aca_pkg;

    localparam int unsigned ACA_WIDTH  = 32;
    localparam int unsigned ACA_WINDOW = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCorrLo = 2'd1,
        StCorrHi = 2'd2
    } aca_state_e;

endpackage

// File: rtl/aca_window_detector.sv
// Conservative speculation-error detector: flags any run of WINDOW-1 propagates
// starting at bit 1 or above.
module aca_window_detector
    import aca_pkg::*;
#(
    parameter int unsigned WIDTH  = ACA_WIDTH,
    parameter int unsigned WINDOW = ACA_WINDOW
) (
    input  logic [WIDTH-1:0] p_i,
    output logic             flag_o
);

    localparam int unsigned NumPos = WIDTH - WINDOW + 1;

    logic [NumPos-1:0] run;

    for (genvar j = 1; j <= NumPos; j++) begin : g_run
        assign run[j-1] = &p_i[j+WINDOW-2:j];
    end

    assign flag_o = |run;

endmodule

// File: rtl/aca32_error_recovery.sv
// Error detection/recovery stage for the windowed speculative-carry adder.
// Optional ACA_RECOVERY_STATS_EN adds saturating transfer/correction counters.
module aca32_error_recovery
    import aca_pkg::*;
#(
    parameter int unsigned WIDTH  = ACA_WIDTH,
    parameter int unsigned WINDOW = ACA_WINDOW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] input1_i,
    input  logic [WIDTH-1:0] input2_i,
    input  logic [WIDTH-1:0] approx_sum_i,
    input  logic             approx_carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             corrected_o
`ifdef ACA_RECOVERY_STATS_EN
    ,
    output logic [31:0]      ops_count_o,
    output logic [31:0]      corr_count_o
`endif
);

    localparam int unsigned Half = WIDTH / 2;

    aca_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [Half-1:0]  lo_q, lo_d;
    logic             hc_q, hc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d, corr_q, corr_d, valid_q, valid_d;

    logic             flag, accept;
    logic [Half:0]    lo_add, hi_add;

    aca_window_detector #(
        .WIDTH (WIDTH),
        .WINDOW(WINDOW)
    ) u_detector (
        .p_i   (input1_i ^ input2_i),
        .flag_o(flag)
    );

    assign ready_o = (state_q == StIdle) & (!valid_q | ready_i);
    assign accept  = valid_i & ready_o;

    assign lo_add = {1'b0, a_q[Half-1:0]} + {1'b0, b_q[Half-1:0]};
    assign hi_add = {1'b0, a_q[WIDTH-1:Half]} + {1'b0, b_q[WIDTH-1:Half]} + {{Half{1'b0}}, hc_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        lo_d    = lo_q;
        hc_d    = hc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        corr_d  = corr_q;
        valid_d = valid_q & !ready_i;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (flag) begin
                        a_d     = input1_i;
                        b_d     = input2_i;
                        state_d = StCorrLo;
                    end else begin
                        sum_d   = approx_sum_i;
                        carry_d = approx_carry_i;
                        corr_d  = 1'b0;
                        valid_d = 1'b1;
                    end
                end
            end
            StCorrLo: begin
                lo_d    = lo_add[Half-1:0];
                hc_d    = lo_add[Half];
                state_d = StCorrHi;
            end
            StCorrHi: begin
                // Hold here rather than clobber an output the consumer has not taken.
                if (!(valid_q & !ready_i)) begin
                    sum_d   = {hi_add[Half-1:0], lo_q};
                    carry_d = hi_add[Half];
                    corr_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            lo_q    <= '0;
            hc_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            corr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lo_q    <= lo_d;
            hc_q    <= hc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            corr_q  <= corr_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o     = valid_q;
    assign sum_o       = sum_q;
    assign carry_o     = carry_q;
    assign corrected_o = corr_q;

`ifdef ACA_RECOVERY_STATS_EN
    logic [31:0] ops_q, ops_d, cnt_q, cnt_d;

    always_comb begin
        ops_d = ops_q;
        cnt_d = cnt_q;
        if (accept && ops_q != '1) ops_d = ops_q + 32'd1;
        if (accept && flag && cnt_q != '1) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ops_q <= '0;
            cnt_q <= '0;
        end else begin
            ops_q <= ops_d;
            cnt_q <= cnt_d;
        end
    end

    assign ops_count_o  = ops_q;
    assign corr_count_o = cnt_q;
`endif

endmodule
